cycle_stopwatch_ctrl: RTL and testbench
=======================================

// Module: cycle_stopwatch_ctrl
//
// PURPOSE
//   Measurement controller for the free-running hardware cycle counter.
//   Samples the counter value on start/stop commands and reports elapsed cycles
//   (modular difference) over a valid/ready result interface.
//   Supports an optional timeout for runaway measurements and abort.
//   Counts completed measurements.
//   Sits between the counter output and the software/register front end.
//
// PARAMETERS
//   W        32  width of counter input and elapsed result
//   TIMEOUT  0   max elapsed cycles before forced completion; 0 = disabled
//   NCNT     16  width of completed-measurement counter
//
// PORTS
//   clk            in   1     clock, single domain
//   rst_n          in   1     asynchronous reset, active-low
//   hc_in          in   W     free-running counter value (registered upstream, +1 per clk)
//   start          in   1     begin measurement (single-cycle pulse, level also tolerated)
//   stop           in   1     end measurement
//   abort          in   1     discard current measurement/result
//   res_elapsed    out  W     elapsed cycles = hc_in@stop - hc_in@start (mod 2^W)
//   res_timeout    out  1     result produced by timeout, not stop
//   res_valid      out  1     result available
//   res_ready      in   1     consumer accepts result
//   busy           out  1     measurement running (state RUN)
//   meas_count     out  NCNT  completed results handed off; saturates at all-ones
//
// BEHAVIOUR
//   Reset values:
//   - All outputs 0; state IDLE; internal t0 = 0.
//
//   States and transitions:
//   - IDLE:
//     - start: t0 <= hc_in, go RUN; busy=1 from next cycle.
//     - stop alone is ignored.
//   - RUN:
//     - stop: res_elapsed <= hc_in - t0 (W-bit modular), res_timeout <= 0, go HOLD.
//     - start is ignored.
//     - Timeout (TIMEOUT != 0) when (hc_in - t0) >= TIMEOUT and no stop this cycle:
//       res_elapsed <= hc_in - t0, res_timeout <= 1, go HOLD.
//     - stop and timeout in the same cycle: stop wins (res_timeout=0).
//   - HOLD:
//     - res_valid=1.
//     - res_elapsed and res_timeout are stable until the handshake (res_valid & res_ready).
//     - On handshake: meas_count++ (saturating).
//       - start in the same cycle: t0 <= hc_in, go RUN (back-to-back measurement).
//       - Otherwise go IDLE.
//     - start without handshake is ignored.
//
//   abort:
//   - Highest priority in every state: go IDLE, clear res_valid and res_timeout.
//   - res_elapsed is retained; meas_count is unchanged.
//   - Any same-cycle start/stop/handshake is ignored.
//
//   Latency:
//   - res_valid rises 1 cycle after the stop or timeout sample.
//   - busy falls in that same cycle.
//
//   Arithmetic:
//   - Difference is unsigned modulo 2^W, so a single counter wrap is correct.
//   - Intervals >= 2^W alias; TIMEOUT bounds this when enabled.
//   - A start and stop on consecutive cycles give elapsed 1.
//
//   res_valid never depends combinationally on res_ready.
//
//   Reset mid-operation: returns to reset values immediately; no result is emitted.
//
// TESTING
//   1. Ramp hc_in from 0; start at hc=100, stop at hc=150 -> next cycle res_valid=1,
//      res_elapsed=50, res_timeout=0, busy=0.
//   2. Wrap: start at hc=0xFFFF_FFF0, stop at hc=0x0000_0010 -> res_elapsed=0x20.
//   3. Backpressure: res_ready=0 for 5 cycles after result, stop/start pulsed meanwhile
//      -> value stable, no restart; ready=1 + start same cycle -> RUN, meas_count=1.
//   4. TIMEOUT=64, start at hc=10, no stop -> result when hc=74: res_elapsed=64,
//      res_timeout=1; stop at hc=74 instead -> res_timeout=0.
//   5. Abort in RUN and in HOLD -> IDLE next cycle, res_valid=0, meas_count unchanged;
//      abort+start same cycle in IDLE -> stays IDLE.
//   6. rst_n low mid-RUN and mid-HOLD -> all outputs 0 asynchronously; meas_count
//      saturation check with NCNT=2 after 5 results -> 3.

Source files
------------

// File: rtl/cycle_stopwatch_ctrl.sv
// Start/stop measurement controller for the free-running cycle counter.
// Reports modular elapsed cycles over a valid/ready result port, with optional timeout and abort.
module cycle_stopwatch_ctrl #(
  parameter int W       = 32,
  parameter int TIMEOUT = 0,
  parameter int NCNT    = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W-1:0]    hc_in,
  input  logic            start,
  input  logic            stop,
  input  logic            abort,
  output logic [W-1:0]    res_elapsed,
  output logic            res_timeout,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            busy,
  output logic [NCNT-1:0] meas_count
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  localparam logic [W-1:0] TIMEOUT_W = W'(TIMEOUT);

  state_t         state;
  logic [W-1:0]   t0;
  logic [W-1:0]   diff;
  logic           timeout_hit;
  logic           handshake;

  // Unsigned wrap-around subtraction makes a single counter rollover harmless.
  assign diff        = hc_in - t0;
  assign timeout_hit = (TIMEOUT != 0) && (diff >= TIMEOUT_W);
  assign handshake   = res_valid & res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      t0          <= '0;
      res_elapsed <= '0;
      res_timeout <= 1'b0;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
      meas_count  <= '0;
    end else if (abort) begin
      state       <= IDLE;
      res_valid   <= 1'b0;
      res_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            t0    <= hc_in;
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (stop || timeout_hit) begin
            res_elapsed <= diff;
            res_timeout <= !stop;
            res_valid   <= 1'b1;
            busy        <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (handshake) begin
            res_valid <= 1'b0;
            if (meas_count != '1)
              meas_count <= meas_count + NCNT'(1);
            if (start) begin
              t0    <= hc_in;
              busy  <= 1'b1;
              state <= RUN;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cycle_stopwatch_ctrl.sv
// Bench for cycle_stopwatch_ctrl: dut_a has TIMEOUT=64, dut_b has timeout disabled
// and a 2-bit measurement counter; both share the same stimulus.
module tb_cycle_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] hc;
  logic        start, stop, abort, res_ready;

  logic [31:0] a_elapsed, b_elapsed;
  logic        a_timeout, b_timeout, a_valid, b_valid, a_busy, b_busy;
  logic [15:0] a_count;
  logic [1:0]  b_count;

  always #5 clk = ~clk;

  cycle_stopwatch_ctrl #(.W(32), .TIMEOUT(64), .NCNT(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .hc_in(hc), .start(start), .stop(stop), .abort(abort),
    .res_elapsed(a_elapsed), .res_timeout(a_timeout), .res_valid(a_valid),
    .res_ready(res_ready), .busy(a_busy), .meas_count(a_count)
  );

  cycle_stopwatch_ctrl #(.W(32), .TIMEOUT(0), .NCNT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .hc_in(hc), .start(start), .stop(stop), .abort(abort),
    .res_elapsed(b_elapsed), .res_timeout(b_timeout), .res_valid(b_valid),
    .res_ready(res_ready), .busy(b_busy), .meas_count(b_count)
  );

  typedef struct {
    string       label;
    logic        valid, busy, tmo;
    logic [31:0] elapsed;
    logic [15:0] count;
    logic        valid_b, busy_b;
    logic [31:0] elapsed_b;
    logic [1:0]  count_b;
  } exp_t;

  typedef struct {
    logic [31:0] hc_start;
    logic [31:0] hc_stop;
    logic [31:0] exp_elapsed;
  } vec_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic        e_valid, e_busy, e_tmo, e_valid_b, e_busy_b;
  logic [31:0] e_elapsed, e_elapsed_b;
  logic [15:0] e_count;
  logic [1:0]  e_count_b;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL scoreboard: queue empty got 0 entries expected 1");
      return;
    end
    e = sb_q.pop_front();
    checkVal({e.label, " a.valid"},   32'(a_valid),   32'(e.valid));
    checkVal({e.label, " a.busy"},    32'(a_busy),    32'(e.busy));
    checkVal({e.label, " a.timeout"}, 32'(a_timeout), 32'(e.tmo));
    checkVal({e.label, " a.elapsed"}, a_elapsed,      e.elapsed);
    checkVal({e.label, " a.count"},   32'(a_count),   32'(e.count));
    checkVal({e.label, " b.valid"},   32'(b_valid),   32'(e.valid_b));
    checkVal({e.label, " b.busy"},    32'(b_busy),    32'(e.busy_b));
    checkVal({e.label, " b.timeout"}, 32'(b_timeout), 32'(0));
    checkVal({e.label, " b.elapsed"}, b_elapsed,      e.elapsed_b);
    checkVal({e.label, " b.count"},   32'(b_count),   32'(e.count_b));
  endtask

  // Called at a negedge: drive, record expectation, then compare at the following negedge.
  task automatic applyStimulus(input string label, input logic st, input logic sp,
                               input logic ab, input logic rdy, input logic [31:0] h);
    exp_t e;
    start = st; stop = sp; abort = ab; res_ready = rdy; hc = h;
    e.label = label;
    e.valid = e_valid; e.busy = e_busy; e.tmo = e_tmo; e.elapsed = e_elapsed; e.count = e_count;
    e.valid_b = e_valid_b; e.busy_b = e_busy_b; e.elapsed_b = e_elapsed_b; e.count_b = e_count_b;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic checkReset(input string label);
    checkVal({label, " a.valid"},   32'(a_valid),   32'(0));
    checkVal({label, " a.busy"},    32'(a_busy),    32'(0));
    checkVal({label, " a.timeout"}, 32'(a_timeout), 32'(0));
    checkVal({label, " a.elapsed"}, a_elapsed,      32'(0));
    checkVal({label, " a.count"},   32'(a_count),   32'(0));
    checkVal({label, " b.valid"},   32'(b_valid),   32'(0));
    checkVal({label, " b.busy"},    32'(b_busy),    32'(0));
    checkVal({label, " b.count"},   32'(b_count),   32'(0));
  endtask

  task automatic clearExpected();
    e_valid = 0; e_busy = 0; e_tmo = 0; e_elapsed = 0; e_count = 0;
    e_valid_b = 0; e_busy_b = 0; e_elapsed_b = 0; e_count_b = 0;
  endtask

  task automatic bumpCount();
    e_count   = e_count + 16'd1;
    e_count_b = (e_count > 16'd3) ? 2'd3 : e_count[1:0];
  endtask

  task automatic expectRun();
    e_busy = 1; e_busy_b = 1; e_valid = 0; e_valid_b = 0;
  endtask

  task automatic expectResult(input logic [31:0] el);
    e_busy = 0; e_busy_b = 0; e_valid = 1; e_valid_b = 1; e_tmo = 0;
    e_elapsed = el; e_elapsed_b = el;
  endtask

  task automatic expectIdle();
    e_busy = 0; e_busy_b = 0; e_valid = 0; e_valid_b = 0; e_tmo = 0;
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{32'd100,        32'd150,        32'd50};
    vecs[1] = '{32'hFFFF_FFF0,  32'h0000_0010,  32'h20};
    vecs[2] = '{32'd500,        32'd501,        32'd1};
    vecs[3] = '{32'd1000,       32'd1063,       32'd63};
    vecs[4] = '{32'hFFFF_FFFF,  32'h0000_0000,  32'd1};

    rst_n = 0; start = 0; stop = 0; abort = 0; res_ready = 0; hc = 0;
    clearExpected();
    #12;
    checkReset("reset");
    @(negedge clk);
    rst_n = 1;

    applyStimulus("idle stop ignored", 0, 1, 0, 0, 32'd90);

    // Five complete measurements; the fifth saturates dut_b's 2-bit counter at 3.
    for (int i = 0; i < 5; i++) begin
      int n;
      n = int'(vecs[i].hc_stop - vecs[i].hc_start);
      expectRun();
      applyStimulus($sformatf("vec%0d start", i), 1, 0, 0, 0, vecs[i].hc_start);
      for (int k = 1; k < n; k++)
        applyStimulus($sformatf("vec%0d run", i), 0, 0, 0, 0, vecs[i].hc_start + 32'(k));
      expectResult(vecs[i].exp_elapsed);
      applyStimulus($sformatf("vec%0d stop", i), 0, 1, 0, 0, vecs[i].hc_stop);
      applyStimulus($sformatf("vec%0d hold", i), 0, 0, 0, 0, vecs[i].hc_stop + 32'd1);
      e_valid = 0; e_valid_b = 0;
      bumpCount();
      applyStimulus($sformatf("vec%0d handshake", i), 0, 0, 0, 1, vecs[i].hc_stop + 32'd2);
    end

    // Backpressure with start/stop noise, then handshake + start back-to-back.
    expectRun();
    applyStimulus("bp start", 1, 0, 0, 0, 32'd2000);
    for (int h = 2001; h < 2010; h++) applyStimulus("bp run", 0, 0, 0, 0, 32'(h));
    expectResult(32'd10);
    applyStimulus("bp stop", 0, 1, 0, 0, 32'd2010);
    for (int j = 0; j < 5; j++)
      applyStimulus($sformatf("bp stall%0d", j), j[0], !j[0], 0, 0, 32'd2011 + 32'(j));
    expectRun();
    bumpCount();
    applyStimulus("bp handshake+start", 1, 0, 0, 1, 32'd2016);
    for (int h = 2017; h < 2020; h++) applyStimulus("bp2 run", 0, 0, 0, 0, 32'(h));
    expectResult(32'd4);
    applyStimulus("bp2 stop", 0, 1, 0, 0, 32'd2020);
    e_valid = 0; e_valid_b = 0;
    bumpCount();
    applyStimulus("bp2 handshake", 0, 0, 0, 1, 32'd2021);

    // Timeout on dut_a only; a start pulse mid-run must not move t0.
    expectRun();
    applyStimulus("to start", 1, 0, 0, 0, 32'd10);
    for (int h = 11; h < 74; h++) applyStimulus("to run", (h == 40), 0, 0, 0, 32'(h));
    e_busy = 0; e_valid = 1; e_tmo = 1; e_elapsed = 32'd64;
    applyStimulus("to fire", 0, 0, 0, 0, 32'd74);
    for (int h = 75; h < 201; h++) applyStimulus("to b still running", 0, 0, 0, 0, 32'(h));
    expectIdle();
    applyStimulus("to abort", 0, 0, 1, 1, 32'd201);

    // Stop and timeout coincide: stop wins.
    expectRun();
    applyStimulus("sw start", 1, 0, 0, 0, 32'd10);
    for (int h = 11; h < 74; h++) applyStimulus("sw run", 0, 0, 0, 0, 32'(h));
    expectResult(32'd64);
    applyStimulus("sw stop", 0, 1, 0, 0, 32'd74);
    e_valid = 0; e_valid_b = 0;
    bumpCount();
    applyStimulus("sw handshake", 0, 0, 0, 1, 32'd75);

    // Abort in RUN, in HOLD (with ready), and together with start in IDLE.
    expectRun();
    applyStimulus("ab start", 1, 0, 0, 0, 32'd300);
    expectIdle();
    applyStimulus("ab in run", 0, 1, 1, 0, 32'd301);
    expectRun();
    applyStimulus("ab2 start", 1, 0, 0, 0, 32'd400);
    for (int h = 401; h < 405; h++) applyStimulus("ab2 run", 0, 0, 0, 0, 32'(h));
    expectResult(32'd5);
    applyStimulus("ab2 stop", 0, 1, 0, 0, 32'd405);
    expectIdle();
    applyStimulus("ab in hold", 0, 0, 1, 1, 32'd406);
    applyStimulus("ab+start idle", 1, 0, 1, 0, 32'd407);
    applyStimulus("ab idle after", 0, 0, 0, 0, 32'd408);

    // Asynchronous reset mid-RUN.
    expectRun();
    applyStimulus("rst run start", 1, 0, 0, 0, 32'd500);
    #2 rst_n = 0;
    #1 checkReset("reset in run");
    clearExpected();
    @(negedge clk);
    rst_n = 1;

    // Asynchronous reset mid-HOLD.
    expectRun();
    applyStimulus("rst hold start", 1, 0, 0, 0, 32'd600);
    for (int h = 601; h < 610; h++) applyStimulus("rst hold run", 0, 0, 0, 0, 32'(h));
    expectResult(32'd10);
    applyStimulus("rst hold stop", 0, 1, 0, 0, 32'd610);
    #2 rst_n = 0;
    #1 checkReset("reset in hold");
    clearExpected();
    @(negedge clk);
    rst_n = 1;

    // Normal operation resumes after reset.
    expectRun();
    applyStimulus("post start", 1, 0, 0, 0, 32'd700);
    applyStimulus("post run", 0, 0, 0, 0, 32'd701);
    applyStimulus("post run", 0, 0, 0, 0, 32'd702);
    expectResult(32'd3);
    applyStimulus("post stop", 0, 1, 0, 0, 32'd703);
    e_valid = 0; e_valid_b = 0;
    bumpCount();
    applyStimulus("post handshake", 0, 0, 0, 1, 32'd704);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
